bicubic_upsample_pipe: RTL and testbench

- Parametrised, pipelined successor of the single-cycle 4x bicubic upsampler.
- Takes one 4x4 source patch of multi-channel pixels per handshake and produces the 4x4 upsampled output patch.
- Separable bicubic filter: vertical pass, then horizontal pass, then rounding and clamping, each in its own registered stage.
- Sits between the patch buffer (bf_*) and the output writer, with full valid/ready backpressure.

---
 rtl/bicubic_pkg.sv | 24 ++
 rtl/bicubic_mac4.sv | 26 ++
 rtl/bicubic_upsample_pipe.sv | 114 +++++++++++
 tb/tb_bicubic_upsample_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// bicubic_pkg: tap matrix, normalisation constants and width helpers
// shared by the pipelined 4x bicubic upsampler.
package bicubic_pkg;

    // Q1.7 taps; the unity tap (128) needs the sign headroom of an int
    localparam int BC_TAPS [4][4] = '{
        '{  0, 128,   0,  0 },
        '{ -9, 111,  29, -3 },
        '{ -8,  72,  72, -8 },
        '{ -3,  29, 111, -9 }
    };

    localparam int BC_SHIFT = 14;
    localparam int BC_RND   = 1 << (BC_SHIFT - 1);

    function automatic int bc_vw(input int cw, input int ww);
        return cw + ww + 2;
    endfunction

    function automatic int bc_hw(input int vw, input int ww);
        return vw + ww + 2;
    endfunction

endpackage

// File: rtl/bicubic_mac4.sv
// bicubic_mac4: combinational signed 4-tap dot product against one
// phase row of the bicubic tap matrix.
module bicubic_mac4
    import bicubic_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 18,
    parameter int PHASE = 0
) (
    input  logic [4*IN_W-1:0]       x,
    output logic signed [OUT_W-1:0] y
);

    logic signed [OUT_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int t = 0; t < 4; t++) begin
            acc = acc + OUT_W'(signed'(x[t*IN_W +: IN_W]))
                      * OUT_W'(BC_TAPS[PHASE][t]);
        end
    end

    assign y = acc;

endmodule

// File: rtl/bicubic_upsample_pipe.sv
// bicubic_upsample_pipe: 3-stage separable 4x bicubic upsampler.
// Define BICUBIC_ROUND_EN for round-half-up normalisation (floor otherwise).
module bicubic_upsample_pipe
    import bicubic_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8,
    parameter int CHANNEL_NUM   = 3,
    parameter int WEIGHT_WIDTH  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    bf_req_valid,
    output logic                                    bcci_req_ready,
    input  logic [16*CHANNEL_NUM*CHANNEL_WIDTH-1:0] bf_req_patch,
    output logic                                    bcci_rsp_valid,
    input  logic                                    bf_rsp_ready,
    output logic [16*CHANNEL_NUM*CHANNEL_WIDTH-1:0] bcci_rsp_data
);

    localparam int CW    = CHANNEL_WIDTH;
    localparam int CN    = CHANNEL_NUM;
    localparam int PIX_W = CN * CW;
    localparam int PW    = 16 * PIX_W;
    localparam int IW    = CW + 1;
    localparam int VW    = bc_vw(CW, WEIGHT_WIDTH);
    localparam int HW    = bc_hw(VW, WEIGHT_WIDTH);
`ifdef BICUBIC_ROUND_EN
    localparam logic signed [HW-1:0] RND = HW'(BC_RND);
`else
    localparam logic signed [HW-1:0] RND = '0;
`endif
    localparam logic signed [HW-1:0] MAXV = HW'((1 << CW) - 1);

    logic s1_v, s2_v, s3_v;
    logic adv3, ld1, ld2, ld3;

    logic signed [VW-1:0] v_d [CN][4][4];
    logic signed [VW-1:0] v_q [CN][4][4];
    logic signed [HW-1:0] h_d [CN][4][4];
    logic signed [HW-1:0] h_q [CN][4][4];
    logic [PW-1:0]        o_d;
    logic signed [HW-1:0] nrm;
    logic [CW-1:0]        ch;

    assign adv3 = s3_v & bf_rsp_ready;
    assign ld3  = ~s3_v | adv3;
    assign ld2  = ~s2_v | ld3;
    assign ld1  = ~s1_v | ld2;

    assign bcci_req_ready = ld1;
    assign bcci_rsp_valid = s3_v;

    // c: channel, i: output row phase, n: column (or output column j)
    for (genvar c = 0; c < CN; c++) begin : g_c
        for (genvar i = 0; i < 4; i++) begin : g_i
            for (genvar n = 0; n < 4; n++) begin : g_n
                logic [4*IW-1:0] col;
                logic [4*VW-1:0] row;
                for (genvar m = 0; m < 4; m++) begin : g_m
                    assign col[m*IW +: IW] =
                        {1'b0, bf_req_patch[(4*m+n)*PIX_W + c*CW +: CW]};
                    assign row[m*VW +: VW] = v_q[c][i][m];
                end
                bicubic_mac4 #(.IN_W(IW), .OUT_W(VW), .PHASE(i)) u_v (
                    .x (col),
                    .y (v_d[c][i][n])
                );
                bicubic_mac4 #(.IN_W(VW), .OUT_W(HW), .PHASE(n)) u_h (
                    .x (row),
                    .y (h_d[c][i][n])
                );
            end
        end
    end

    always_comb begin
        o_d = '0;
        nrm = '0;
        ch  = '0;
        for (int c = 0; c < CN; c++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    nrm = (h_q[c][i][j] + RND) >>> BC_SHIFT;
                    if (nrm < 0)
                        ch = '0;
                    else if (nrm > MAXV)
                        ch = '1;
                    else
                        ch = nrm[CW-1:0];
                    o_d[(4*i+j)*PIX_W + c*CW +: CW] = ch;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v          <= 1'b0;
            s2_v          <= 1'b0;
            s3_v          <= 1'b0;
            v_q           <= '{default: '0};
            h_q           <= '{default: '0};
            bcci_rsp_data <= '0;
        end else begin
            if (ld1) s1_v <= bf_req_valid;
            if (ld1 && bf_req_valid) v_q <= v_d;
            if (ld2) s2_v <= s1_v;
            if (ld2 && s1_v) h_q <= h_d;
            if (ld3) s3_v <= s2_v;
            if (ld3 && s2_v) bcci_rsp_data <= o_d;
        end
    end

endmodule

// File: tb/tb_bicubic_upsample_pipe.sv
// tb_bicubic_upsample_pipe: scoreboard bench against a behavioural
// bicubic model; directed edge patches, backpressure and reset.
module tb_bicubic_upsample_pipe;

    localparam int CW    = 8;
    localparam int CN    = 3;
    localparam int PIX_W = CN * CW;
    localparam int PW    = 16 * PIX_W;

    localparam int TAP [4][4] = '{
        '{  0, 128,   0,  0 },
        '{ -9, 111,  29, -3 },
        '{ -8,  72,  72, -8 },
        '{ -3,  29, 111, -9 }
    };
`ifdef BICUBIC_ROUND_EN
    localparam longint RND   = 8192;
    localparam int     ROUND = 1;
`else
    localparam longint RND   = 0;
    localparam int     ROUND = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bf_req_valid = 1'b0;
    logic          bf_rsp_ready = 1'b0;
    logic [PW-1:0] bf_req_patch = '0;
    logic          bcci_req_ready;
    logic          bcci_rsp_valid;
    logic [PW-1:0] bcci_rsp_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int last_acc = 0;
    bit rand_ready = 0;
    bit mon_stall = 0;
    logic [PW-1:0] held;
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] got_q [$];
    logic [PW-1:0] pats [6];

    bicubic_upsample_pipe #(
        .CHANNEL_WIDTH (CW),
        .CHANNEL_NUM   (CN),
        .WEIGHT_WIDTH  (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bf_req_valid   (bf_req_valid),
        .bcci_req_ready (bcci_req_ready),
        .bf_req_patch   (bf_req_patch),
        .bcci_rsp_valid (bcci_rsp_valid),
        .bf_rsp_ready   (bf_rsp_ready),
        .bcci_rsp_data  (bcci_rsp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk)
        if (rand_ready) bf_rsp_ready = ($urandom_range(0, 3) != 0);

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int pix(input logic [PW-1:0] p, input int m,
                               input int n, input int c);
        return int'(p[(4*m+n)*PIX_W + c*CW +: CW]);
    endfunction

    // Separable bicubic filter straight from the tap table, 64-bit math
    function automatic logic [PW-1:0] model(input logic [PW-1:0] p);
        logic [PW-1:0] o;
        longint v, h;
        o = '0;
        for (int c = 0; c < CN; c++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    h = 0;
                    for (int n = 0; n < 4; n++) begin
                        v = 0;
                        for (int m = 0; m < 4; m++)
                            v += TAP[i][m] * pix(p, m, n, c);
                        h += TAP[j][n] * v;
                    end
                    h = (h + RND) >>> 14;
                    if (h < 0) h = 0;
                    if (h > 255) h = 255;
                    o[(4*i+j)*PIX_W + c*CW +: CW] = h[CW-1:0];
                end
        return o;
    endfunction

    function automatic logic [PW-1:0] rows(input int r0, input int r1,
                                           input int r2, input int r3);
        logic [PW-1:0] p;
        int r [4];
        r = '{r0, r1, r2, r3};
        p = '0;
        for (int k = 0; k < 16; k++)
            for (int c = 0; c < CN; c++)
                p[k*PIX_W + c*CW +: CW] = CW'(r[k/4]);
        return p;
    endfunction

    function automatic logic [PW-1:0] rnd_patch();
        logic [PW-1:0] p;
        for (int w = 0; w < PW/32; w++) p[w*32 +: 32] = $urandom();
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [PW-1:0] got,
                        input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the handshake
    task automatic send(input logic [PW-1:0] p);
        int g;
        g = 0;
        bf_req_valid = 1'b1;
        bf_req_patch = p;
        #1;
        while (!bcci_req_ready && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!bcci_req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0, expected ready=1");
        end else begin
            exp_q.push_back(model(p));
            n_acc++;
            last_acc = cyc;
        end
        @(negedge clk);
        bf_req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_latency(input string name);
        int g;
        g = 0;
        while (!bcci_rsp_valid && g < 10) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk(name, cyc - last_acc, 3);
    endtask

    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                mon_stall = 0;
                continue;
            end
            if (mon_stall && bcci_rsp_valid)
                chkv("hold_stable", bcci_rsp_data, held);
            mon_stall = 0;
            if (bcci_rsp_valid && !bf_rsp_ready) begin
                mon_stall = 1;
                held = bcci_rsp_data;
            end
            if (bcci_rsp_valid && bf_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected none",
                             bcci_rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chkv("patch", bcci_rsp_data, e);
                end
                got_q.push_back(bcci_rsp_data);
                n_out++;
            end
        end
    end

    initial begin
        int base;
        int seen;
        int a0;
        logic [PW-1:0] p;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", bcci_req_ready, 1);
        chk("rst_rsp_valid", bcci_rsp_valid, 0);
        chkv("rst_rsp_data", bcci_rsp_data, '0);
        rst_n = 1'b1;
        bf_rsp_ready = 1'b1;
        @(negedge clk);

        base = got_q.size();
        send(rows(100, 100, 100, 100));
        wait_latency("flat_latency");
        drain();
        chkv("flat_100", got_q[base], rows(100, 100, 100, 100));

        base = got_q.size();
        p = rnd_patch();
        send(p);
        drain();
        for (int c = 0; c < CN; c++)
            chk("phase0_o00", pix(got_q[base], 0, 0, c), pix(p, 1, 1, c));

        base = got_q.size();
        send(rows(0, 255, 255, 255));
        send(rows(255, 0, 0, 0));
        send(rows(0, 1, 0, 0));
        drain();
        for (int j = 0; j < 4; j++)
            for (int c = 0; c < CN; c++) begin
                chk("clamp_hi_o1", pix(got_q[base], 1, j, c), 255);
                chk("clamp_lo_o1", pix(got_q[base+1], 1, j, c), 0);
                chk("clamp_lo_o3", pix(got_q[base+1], 3, j, c), 0);
                chk("round_o2", pix(got_q[base+2], 2, j, c), ROUND);
            end

        base = got_q.size();
        a0 = n_acc;
        for (int k = 0; k < 6; k++) pats[k] = rnd_patch();
        fork
            for (int k = 0; k < 6; k++) send(pats[k]);
            begin
                int g;
                g = 0;
                while (n_acc - a0 < 2 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                bf_rsp_ready = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                chk("stall_req_ready", bcci_req_ready, 0);
                chk("stall_inflight", n_acc - n_out, 3);
                @(negedge clk);
                bf_rsp_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", got_q.size() - base, 6);
        for (int k = 0; k < 6; k++)
            chkv("stream_order", got_q[base+k], model(pats[k]));

        rand_ready = 1;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(rnd_patch());
        end
        drain();
        @(negedge clk);
        rand_ready = 0;
        bf_rsp_ready = 1'b1;

        @(negedge clk);
        bf_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(rnd_patch());
        #1;
        chk("full_req_ready", bcci_req_ready, 0);
        chk("full_rsp_valid", bcci_rsp_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_rsp_valid", bcci_rsp_valid, 0);
        chk("mid_rst_req_ready", bcci_req_ready, 1);
        chkv("mid_rst_rsp_data", bcci_rsp_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bf_rsp_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (bcci_rsp_valid) seen++;
        end
        chk("post_rst_idle", seen, 0);
        base = got_q.size();
        p = rnd_patch();
        send(p);
        wait_latency("post_rst_latency");
        drain();
        chkv("post_rst_patch", got_q[base], model(p));

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
